// File: rtl/mbtrain_sb_tx_arbiter_pkg.sv
// Shared types and constants for the MBTRAIN sideband transmit arbiter.
package mbtrain_sb_tx_arbiter_pkg;

    localparam int SB_MSG_W      = 4;
    localparam int SB_SUBSTATE_W = 4;

    // MBTRAIN substate codes carried in the upper nibble of the packet ID
    typedef enum logic [3:0] {
        SS_VALVREF        = 4'd0,
        SS_DATAVREF       = 4'd1,
        SS_SPEEDIDLE      = 4'd2,
        SS_TXSELFCAL      = 4'd3,
        SS_RXCLKCAL       = 4'd4,
        SS_VALTRAINCENTER = 4'd5,
        SS_VALTRAINVREF   = 4'd6,
        SS_DATATRAINCTR1  = 4'd7,
        SS_LINKSPEED      = 4'd8
    } mbtrain_substate_e;

    // Per-FSM sideband message codes
    typedef enum logic [3:0] {
        MSG_NONE       = 4'd0,
        MSG_START_REQ  = 4'd1,
        MSG_START_RESP = 4'd2,
        MSG_END_REQ    = 4'd3,
        MSG_END_RESP   = 4'd4
    } sb_msg_e;

    localparam logic SRC_TX = 1'b0;
    localparam logic SRC_RX = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_FALL = 2'd2,
        ST_RELEASE   = 2'd3
    } arb_state_e;

    // Round-robin pick: a lone requester wins, a tie goes to the side not served last
    function automatic logic pick_src(input logic valid_tx, input logic valid_rx,
                                      input logic last_src);
        if (valid_tx && valid_rx) return ~last_src;
        return valid_rx ? SRC_RX : SRC_TX;
    endfunction

endpackage

// File: rtl/mbtrain_sb_tx_arbiter_if.sv
// Request/packet bus between the MBTRAIN substate FSMs, the arbiter and the sideband encoder.
interface mbtrain_sb_tx_arbiter_if
    import mbtrain_sb_tx_arbiter_pkg::*;
#(
    parameter int MSG_W      = SB_MSG_W,
    parameter int SUBSTATE_W = SB_SUBSTATE_W
);
    logic                        i_en;
    logic [SUBSTATE_W-1:0]       i_substate;
    logic                        i_valid_tx;
    logic [MSG_W-1:0]            i_msg_tx;
    logic                        i_valid_rx;
    logic [MSG_W-1:0]            i_msg_rx;
    logic                        i_sb_busy;
    logic                        o_sb_valid;
    logic [SUBSTATE_W+MSG_W-1:0] o_sb_msg_id;
    logic                        o_sb_src;
    logic                        o_grant_tx;
    logic                        o_grant_rx;
    logic                        o_busy_negedge_detected;
    logic                        o_timeout;

    // Requesters and serializer side
    modport master (
        output i_en, i_substate, i_valid_tx, i_msg_tx, i_valid_rx, i_msg_rx, i_sb_busy,
        input  o_sb_valid, o_sb_msg_id, o_sb_src, o_grant_tx, o_grant_rx,
               o_busy_negedge_detected, o_timeout
    );

    // Arbiter side
    modport slave (
        input  i_en, i_substate, i_valid_tx, i_msg_tx, i_valid_rx, i_msg_rx, i_sb_busy,
        output o_sb_valid, o_sb_msg_id, o_sb_src, o_grant_tx, o_grant_rx,
               o_busy_negedge_detected, o_timeout
    );
endinterface

// File: rtl/mbtrain_sb_tx_arbiter_negedge_det.sv
// Falling-edge detector: previous sample held in a flop, fall is high in the first low cycle.
module mbtrain_sb_tx_arbiter_negedge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic fall
);
    logic d_p1;

    // Track the previous cycle's value of d
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d_p1 <= 1'b0;
        else        d_p1 <= d;
    end

    assign fall = d_p1 & ~d;
endmodule

// File: rtl/mbtrain_sb_tx_arbiter.sv
// Round-robin arbiter sharing the sideband TX path between the MBTRAIN TX- and RX-side FSMs.
module mbtrain_sb_tx_arbiter
    import mbtrain_sb_tx_arbiter_pkg::*;
#(
    parameter int MSG_W          = SB_MSG_W,
    parameter int SUBSTATE_W     = SB_SUBSTATE_W,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_CNT_W       = 13
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mbtrain_sb_tx_arbiter_if.slave bus
);
    localparam int                  ID_W    = SUBSTATE_W + MSG_W;
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e          state;
    logic                last_src;
    logic                src_q;
    logic                sb_valid_q;
    logic                grant_tx_q;
    logic                grant_rx_q;
    logic                pulse_q;
    logic                timeout_q;
    logic [ID_W-1:0]     msg_id_q;
    logic [TO_CNT_W-1:0] to_cnt;

    logic                busy_fall;
    logic                any_req;
    logic                req_src;
    logic [MSG_W-1:0]    req_msg;
    logic                granted_valid;

    mbtrain_sb_tx_arbiter_negedge_det u_busy_det (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.i_sb_busy),
        .fall  (busy_fall)
    );

    assign any_req       = bus.i_valid_tx | bus.i_valid_rx;
    assign req_src       = pick_src(bus.i_valid_tx, bus.i_valid_rx, last_src);
    assign req_msg       = (req_src == SRC_RX) ? bus.i_msg_rx : bus.i_msg_tx;
    assign granted_valid = (src_q == SRC_RX) ? bus.i_valid_rx : bus.i_valid_tx;

    // Arbiter FSM: grant, issue, wait for serializer done, release; all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_src   <= SRC_RX;
            src_q      <= SRC_TX;
            sb_valid_q <= 1'b0;
            grant_tx_q <= 1'b0;
            grant_rx_q <= 1'b0;
            msg_id_q   <= '0;
            to_cnt     <= '0;
            pulse_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            pulse_q   <= 1'b0;
            timeout_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.i_en && any_req) begin
                        state      <= ST_ISSUE;
                        src_q      <= req_src;
                        last_src   <= req_src;
                        grant_tx_q <= (req_src == SRC_TX);
                        grant_rx_q <= (req_src == SRC_RX);
                        sb_valid_q <= 1'b1;
                        msg_id_q   <= {bus.i_substate, req_msg};
                        to_cnt     <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (bus.i_en && bus.i_sb_busy) begin
                        state      <= ST_WAIT_FALL;
                        sb_valid_q <= 1'b0;
                    end else if (bus.i_en && granted_valid && to_cnt != TO_LAST) begin
                        to_cnt <= to_cnt + 1'b1;
                    end else begin
                        // Disable, abort (requester withdrew) or timeout; only timeout pulses
                        timeout_q  <= bus.i_en && granted_valid;
                        state      <= ST_IDLE;
                        src_q      <= SRC_TX;
                        sb_valid_q <= 1'b0;
                        grant_tx_q <= 1'b0;
                        grant_rx_q <= 1'b0;
                        msg_id_q   <= '0;
                    end
                end
                ST_WAIT_FALL: begin
                    // The packet is on the wire, so it always completes even if disabled
                    if (busy_fall) begin
                        pulse_q <= 1'b1;
                        if (bus.i_en) begin
                            state <= ST_RELEASE;
                        end else begin
                            state      <= ST_IDLE;
                            src_q      <= SRC_TX;
                            grant_tx_q <= 1'b0;
                            grant_rx_q <= 1'b0;
                            msg_id_q   <= '0;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (!bus.i_en || !granted_valid) begin
                        state      <= ST_IDLE;
                        src_q      <= SRC_TX;
                        grant_tx_q <= 1'b0;
                        grant_rx_q <= 1'b0;
                        msg_id_q   <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_sb_valid              = sb_valid_q;
    assign bus.o_sb_msg_id             = msg_id_q;
    assign bus.o_sb_src                = src_q;
    assign bus.o_grant_tx              = grant_tx_q;
    assign bus.o_grant_rx              = grant_rx_q;
    assign bus.o_busy_negedge_detected = pulse_q;
    assign bus.o_timeout               = timeout_q;
endmodule
